// File: rtl/uart_rx_if.sv
// Host-side port bundle of uart_rx: FIFO read port plus status and error flags.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          rd_en;
   logic          err_clr;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [CW-1:0] fifo_count;
   logic          frame_err;
   logic          overrun_err;
   logic          rx_busy;
`ifdef UART_RX_PARITY_EN
   logic          parity_err;

   modport master (
      input  rd_en, err_clr,
      output rx_data, rx_valid, fifo_count, frame_err, overrun_err, rx_busy, parity_err
   );
   modport slave (
      output rd_en, err_clr,
      input  rx_data, rx_valid, fifo_count, frame_err, overrun_err, rx_busy, parity_err
   );
`else
   modport master (
      input  rd_en, err_clr,
      output rx_data, rx_valid, fifo_count, frame_err, overrun_err, rx_busy
   );
   modport slave (
      output rd_en, err_clr,
      input  rx_data, rx_valid, fifo_count, frame_err, overrun_err, rx_busy
   );
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver (LSB first, idle high) feeding a show-ahead FIFO, with sticky
// framing/overrun flags. Define UART_RX_PARITY_EN to add a parity bit and parity_err.
module uart_rx #(
   parameter int CLKS_PER_BIT = 260,
   parameter int FIFO_DEPTH   = 4
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD   = 1'b0
`endif
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx_serial,
   uart_rx_if.master bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd5;
`endif

   logic             sync1, rxs;
   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             at_last, push, frame_evt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx_serial;
         rxs   <= sync1;
      end
   end

   assign at_last   = (cnt == CNT_LAST);
   assign frame_evt = (state == STOP) && at_last && !rxs;

`ifdef UART_RX_PARITY_EN
   logic par_bad, parity_evt, parity_err_q;
   assign parity_evt = (state == PARITY) && at_last && (rxs != ((^shreg) ^ PARITY_ODD));
   // A byte with bad parity is dropped even when its stop bit is good.
   assign push       = (state == STOP) && at_last && rxs && !par_bad;

   always_ff @(posedge clk) begin
      if (rst || state == START) par_bad <= 1'b0;
      else if (parity_evt)       par_bad <= 1'b1;
   end
`else
   assign push = (state == STOP) && at_last && rxs;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            IDLE: if (!rxs) begin
               state <= START;
               cnt   <= '0;
            end
            START: if (cnt == CNT_MID) begin
               cnt     <= '0;
               bit_idx <= '0;
               state   <= rxs ? IDLE : DATA;
            end else cnt <= cnt + 1'b1;
            DATA: if (at_last) begin
               cnt            <= '0;
               shreg[bit_idx] <= rxs;
               bit_idx        <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == 3'd7) state <= PARITY;
`else
               if (bit_idx == 3'd7) state <= STOP;
`endif
            end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            PARITY: if (at_last) begin
               cnt   <= '0;
               state <= STOP;
            end else cnt <= cnt + 1'b1;
`endif
            STOP: if (at_last) begin
               cnt   <= '0;
               state <= rxs ? IDLE : BREAK;
            end else cnt <= cnt + 1'b1;
            // Wait out a held-low line so a break is not mistaken for a new start bit.
            BREAK: if (rxs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             full, empty, pop, wr, overrun_evt;

   assign full        = (count == CW'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign pop         = bus.rd_en && !empty;
   assign wr          = push && (!full || pop);
   assign overrun_evt = push && full && !pop;

   // NOTE: the storage array has no reset; occupancy lives in count and rx_data is masked while empty.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   logic frame_err_q, overrun_err_q;

   // An error event in the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         frame_err_q   <= (frame_err_q && !bus.err_clr) || frame_evt;
         overrun_err_q <= (overrun_err_q && !bus.err_clr) || overrun_evt;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) parity_err_q <= 1'b0;
      else     parity_err_q <= (parity_err_q && !bus.err_clr) || parity_evt;
   end
   assign bus.parity_err = parity_err_q;
`endif

   assign bus.rx_data     = empty ? 8'h00 : mem[rd_ptr];
   assign bus.rx_valid    = !empty;
   assign bus.fifo_count  = count;
   assign bus.frame_err   = frame_err_q;
   assign bus.overrun_err = overrun_err_q;
   assign bus.rx_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (8N1 build): directed frame/glitch/break/reset
// sequences, a table of FIFO push/pop vectors, and random traffic against a queue model.
module tb_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   // Edge (counted from the line falling) at which the stop bit is sampled:
   // 3 clk to START, half a bit to the start-bit sample, then 8 data bits + stop.
   localparam int STOP_EDGE = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

   typedef enum int {OP_SEND, OP_POP, OP_CLR} op_e;
   typedef struct {
      op_e        op;
      logic [7:0] data;
      bit         sim_pop;
      int         exp_count;
      logic [7:0] exp_head;
      bit         exp_ovr;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic rx_serial;
   int   n_checks = 0;
   int   n_fail   = 0;

   vec_t       vecs[$];
   logic [7:0] mq[$];
   bit         m_ferr, m_ovr;

   always #5 clk = ~clk;

   uart_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .bus       (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input int exp_count, input logic [7:0] exp_head,
                              input bit exp_ferr, input bit exp_ovr);
      check({name, " count"}, 32'(bus.fifo_count), 32'(exp_count));
      check({name, " valid"}, 32'(bus.rx_valid), (exp_count != 0) ? 1 : 0);
      if (exp_count != 0) check({name, " head"}, 32'(bus.rx_data), 32'(exp_head));
      check({name, " frame_err"}, 32'(bus.frame_err), 32'(exp_ferr));
      check({name, " overrun_err"}, 32'(bus.overrun_err), 32'(exp_ovr));
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at the current negedge. rd_en / err_clr are raised for the
   // single cycle that ends at edge (rd_at+1) / (clr_at+1). push_at reports the first
   // negedge at which fifo_count differed from its starting value (-1 if never).
   task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at,
                             input int clr_at, output int push_at);
      logic [9:0]  bits;
      logic [31:0] c0;
      int          n;
      bits    = {stop, b, 1'b0};
      c0      = 32'(bus.fifo_count);
      push_at = -1;
      n       = 0;
      for (int i = 0; i < 10; i++) begin
         rx_serial = bits[i];
         for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            n++;
            if (push_at < 0 && 32'(bus.fifo_count) != c0) push_at = n;
            bus.rd_en   = (n == rd_at);
            bus.err_clr = (n == clr_at);
         end
      end
      bus.rd_en   = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   task automatic pop_one();
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic clr_pulse();
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
   endtask

   task automatic add_vec(input op_e op, input logic [7:0] data, input bit sim_pop,
                          input int exp_count, input logic [7:0] exp_head, input bit exp_ovr);
      vec_t v;
      v.op = op; v.data = data; v.sim_pop = sim_pop;
      v.exp_count = exp_count; v.exp_head = exp_head; v.exp_ovr = exp_ovr;
      vecs.push_back(v);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         pa;
      int         r, sz, rd_at;
      bit         dop, good;
      logic [7:0] b;

      // Overrun sequence, then simultaneous push/pop on a full FIFO.
      add_vec(OP_SEND, 8'h01, 0, 1, 8'h01, 0);
      add_vec(OP_SEND, 8'h02, 0, 2, 8'h01, 0);
      add_vec(OP_SEND, 8'h03, 0, 3, 8'h01, 0);
      add_vec(OP_SEND, 8'h04, 0, 4, 8'h01, 0);
      add_vec(OP_SEND, 8'h05, 0, 4, 8'h01, 1);
      add_vec(OP_POP,  8'h00, 0, 3, 8'h02, 1);
      add_vec(OP_POP,  8'h00, 0, 2, 8'h03, 1);
      add_vec(OP_POP,  8'h00, 0, 1, 8'h04, 1);
      add_vec(OP_POP,  8'h00, 0, 0, 8'h00, 1);
      add_vec(OP_CLR,  8'h00, 0, 0, 8'h00, 0);
      add_vec(OP_SEND, 8'h10, 0, 1, 8'h10, 0);
      add_vec(OP_SEND, 8'h11, 0, 2, 8'h10, 0);
      add_vec(OP_SEND, 8'h12, 0, 3, 8'h10, 0);
      add_vec(OP_SEND, 8'h13, 0, 4, 8'h10, 0);
      add_vec(OP_SEND, 8'h14, 1, 4, 8'h11, 0);
      add_vec(OP_POP,  8'h00, 0, 3, 8'h12, 0);
      add_vec(OP_POP,  8'h00, 0, 2, 8'h13, 0);
      add_vec(OP_POP,  8'h00, 0, 1, 8'h14, 0);
      add_vec(OP_POP,  8'h00, 0, 0, 8'h00, 0);

      rst = 1'b1; rx_serial = 1'b1; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
      wait_clks(3);
      check_state("reset", 0, 8'h00, 0, 0);
      check("reset rx_data", 32'(bus.rx_data), 0);
      check("reset rx_busy", 32'(bus.rx_busy), 0);
      rst = 1'b0;
      wait_clks(4);

      // Single frame and its push latency.
      send_frame(8'hA5, 1'b1, -1, -1, pa);
      check("frame push latency", 32'(pa), 32'(STOP_EDGE));
      check_state("frame", 1, 8'hA5, 0, 0);
      check("frame rx_busy", 32'(bus.rx_busy), 0);
      pop_one();
      check_state("frame pop", 0, 8'h00, 0, 0);

      // Short low glitch is rejected at the start-bit sample.
      rx_serial = 1'b0;
      wait_clks(5);
      check("glitch busy", 32'(bus.rx_busy), 1);
      rx_serial = 1'b1;
      wait_clks(20);
      check("glitch idle", 32'(bus.rx_busy), 0);
      check_state("glitch", 0, 8'h00, 0, 0);

      // Framing error followed by a held break.
      send_frame(8'h3C, 1'b0, -1, -1, pa);
      check_state("ferr", 0, 8'h00, 1, 0);
      check("ferr busy", 32'(bus.rx_busy), 1);
      wait_clks(64);
      check("break busy", 32'(bus.rx_busy), 1);
      check("break count", 32'(bus.fifo_count), 0);
      rx_serial = 1'b1;
      wait_clks(6);
      check("break released", 32'(bus.rx_busy), 0);
      send_frame(8'h55, 1'b1, -1, -1, pa);
      check_state("after break", 1, 8'h55, 1, 0);
      clr_pulse();
      check_state("ferr clear", 1, 8'h55, 0, 0);
      pop_one();
      check("after break pop", 32'(bus.fifo_count), 0);

      // err_clr in the same cycle as a framing error leaves the flag set.
      send_frame(8'h99, 1'b0, -1, STOP_EDGE - 1, pa);
      check("clr vs event", 32'(bus.frame_err), 1);
      rx_serial = 1'b1;
      wait_clks(6);
      clr_pulse();
      check_state("clr after", 0, 8'h00, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_SEND: send_frame(vecs[i].data, 1'b1, vecs[i].sim_pop ? STOP_EDGE - 1 : -1, -1, pa);
            OP_POP:  pop_one();
            default: clr_pulse();
         endcase
         wait_clks(2);
         check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_head, 0, vecs[i].exp_ovr);
      end

      // Random traffic against a queue model of the FIFO and flags.
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         b = 8'($urandom);
         if (r <= 5) begin
            good  = (r != 5);
            dop   = ($urandom_range(0, 2) == 0);
            rd_at = dop ? STOP_EDGE - 1 : -1;
            send_frame(b, good, rd_at, -1, pa);
            sz  = mq.size();
            dop = dop && (sz > 0);
            if (good) begin
               if (sz == DEPTH && !dop) m_ovr = 1'b1;
               else begin
                  if (dop) void'(mq.pop_front());
                  mq.push_back(b);
               end
            end else begin
               m_ferr = 1'b1;
               if (dop) void'(mq.pop_front());
            end
            rx_serial = 1'b1;
            wait_clks(6);
         end else if (r <= 8) begin
            pop_one();
            if (mq.size() > 0) void'(mq.pop_front());
            wait_clks(1);
         end else begin
            clr_pulse();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            wait_clks(1);
         end
         check_state($sformatf("rnd%0d", it), mq.size(), (mq.size() > 0) ? mq[0] : 8'h00, m_ferr, m_ovr);
      end

      // Reset during data bit 3 of 0x7E, with stored data and a set flag beforehand.
      send_frame(8'h42, 1'b1, -1, -1, pa);
      send_frame(8'h00, 1'b0, -1, -1, pa);
      rx_serial = 1'b1;
      wait_clks(6);
      check("pre-reset valid", 32'(bus.rx_valid), 1);
      check("pre-reset frame_err", 32'(bus.frame_err), 1);
      b = 8'h7E;
      rx_serial = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 3; i++) begin
         rx_serial = b[i];
         wait_clks(CPB);
      end
      rx_serial = b[3];
      wait_clks(CPB / 2);
      check("mid-frame busy", 32'(bus.rx_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_state("mid reset", 0, 8'h00, 0, 0);
      check("mid reset rx_data", 32'(bus.rx_data), 0);
      check("mid reset rx_busy", 32'(bus.rx_busy), 0);
      rx_serial = 1'b1;
      wait_clks(2 * CPB);
      send_frame(8'hFF, 1'b1, -1, -1, pa);
      check_state("post reset", 1, 8'hFF, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
